// File: rtl/mmu_rr_arb_sched.sv
// Round-robin request merger with a single registered output slot and an
// outstanding-transaction limiter that routes completions back to requesters.
module mmu_rr_arb_sched #(
  parameter int NUM_PORTS  = 11,
  parameter int DATA_WIDTH = 88,
  parameter int MAX_OUTST  = 4
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic [NUM_PORTS-1:0]            i_req_valid,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_PORTS-1:0]            o_req_ready,
  output logic                            o_valid,
  output logic [DATA_WIDTH-1:0]           o_data,
  output logic [3:0]                      o_port_id,
  input  logic                            i_ready,
  input  logic                            i_rsp_valid,
  input  logic [3:0]                      i_rsp_id,
  output logic [NUM_PORTS-1:0]            o_rsp_valid,
  output logic [3:0]                      o_outst,
  output logic                            o_err
);

  logic [3:0]            last_grant_q, last_grant_d;
  logic                  slot_vld_q, slot_vld_d;
  logic [DATA_WIDTH-1:0] slot_data_q, slot_data_d;
  logic [3:0]            slot_id_q, slot_id_d;
  logic [3:0]            outst_q, outst_d;
  logic                  err_q, err_d;

  logic                  xfer, slot_free, can_issue, hs;
  logic [4:0]            outst_sum;
  logic                  gnt_vld;
  logic [3:0]            gnt_id;
  logic [DATA_WIDTH-1:0] gnt_data;
  logic                  rsp_in_range, rsp_legal, rsp_ok;

  assign xfer      = slot_vld_q & i_ready;
  assign slot_free = ~slot_vld_q | i_ready;
  assign outst_sum = {1'b0, outst_q} + {4'd0, xfer};
  // rstn gates the combinational outputs so nothing handshakes during reset
  assign can_issue = rstn & slot_free & (outst_sum < 5'(MAX_OUTST));
  assign hs        = can_issue & gnt_vld;

  always_comb begin : rr_pick
    logic [4:0] scan;
    logic [3:0] idx;
    scan    = '0;
    idx     = '0;
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int off = 1; off <= NUM_PORTS; off++) begin
      scan = {1'b0, last_grant_q} + 5'(off);
      if (scan >= 5'(NUM_PORTS)) scan = scan - 5'(NUM_PORTS);
      idx = scan[3:0];
      if (!gnt_vld && i_req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx;
      end
    end
  end

  always_comb begin : gnt_mux
    gnt_data    = '0;
    o_req_ready = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt_id == 4'(p)) gnt_data = i_req_data[p*DATA_WIDTH +: DATA_WIDTH];
      o_req_ready[p] = hs & (gnt_id == 4'(p));
    end
  end

  assign rsp_in_range = {1'b0, i_rsp_id} < 5'(NUM_PORTS);
  assign rsp_legal    = rsp_in_range & (outst_q != 4'd0);
  assign rsp_ok       = rstn & i_rsp_valid & rsp_legal;

  always_comb begin : rsp_route
    o_rsp_valid = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      o_rsp_valid[p] = rsp_ok & (i_rsp_id == 4'(p));
    end
  end

  always_comb begin : next_state
    slot_vld_d   = slot_vld_q;
    slot_data_d  = slot_data_q;
    slot_id_d    = slot_id_q;
    last_grant_d = last_grant_q;
    outst_d      = outst_q;
    err_d        = err_q | (i_rsp_valid & ~rsp_legal);
    if (hs) begin
      slot_vld_d   = 1'b1;
      slot_data_d  = gnt_data;
      slot_id_d    = gnt_id;
      last_grant_d = gnt_id;
    end else if (xfer) begin
      slot_vld_d = 1'b0;
    end
    // simultaneous issue and completion cancel out
    case ({xfer, rsp_ok})
      2'b10:   outst_d = outst_q + 4'd1;
      2'b01:   outst_d = outst_q - 4'd1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= 4'(NUM_PORTS - 1);
      slot_vld_q   <= 1'b0;
      slot_data_q  <= '0;
      slot_id_q    <= '0;
      outst_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      slot_vld_q   <= slot_vld_d;
      slot_data_q  <= slot_data_d;
      slot_id_q    <= slot_id_d;
      outst_q      <= outst_d;
      err_q        <= err_d;
    end
  end

  assign o_valid   = slot_vld_q;
  assign o_data    = slot_data_q;
  assign o_port_id = slot_id_q;
  assign o_outst   = outst_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_mmu_rr_arb_sched.sv
// Directed bench for mmu_rr_arb_sched: arbitration order, slot hold,
// outstanding limit, completion routing, error flag and reset behaviour.
module tb_mmu_rr_arb_sched;

  localparam int NP = 11;
  localparam int DW = 88;

  logic              clk;
  logic              rstn;
  logic [NP-1:0]     i_req_valid;
  logic [NP*DW-1:0]  i_req_data;
  logic [NP-1:0]     o_req_ready;
  logic              o_valid;
  logic [DW-1:0]     o_data;
  logic [3:0]        o_port_id;
  logic              i_ready;
  logic              i_rsp_valid;
  logic [3:0]        i_rsp_id;
  logic [NP-1:0]     o_rsp_valid;
  logic [3:0]        o_outst;
  logic              o_err;

  int n_cmp = 0;
  int n_mis = 0;

  mmu_rr_arb_sched #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .MAX_OUTST(4)) dut (
    .clk(clk), .rstn(rstn),
    .i_req_valid(i_req_valid), .i_req_data(i_req_data), .o_req_ready(o_req_ready),
    .o_valid(o_valid), .o_data(o_data), .o_port_id(o_port_id), .i_ready(i_ready),
    .i_rsp_valid(i_rsp_valid), .i_rsp_id(i_rsp_id), .o_rsp_valid(o_rsp_valid),
    .o_outst(o_outst), .o_err(o_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [DW-1:0] pay(input int k, input logic [7:0] salt);
    return {salt, 72'h0, 8'(k)};
  endfunction

  function automatic logic [NP-1:0] oh(input int k);
    logic [NP-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rstn        = 1'b0;
    i_req_valid = '0;
    i_ready     = 1'b0;
    i_rsp_valid = 1'b0;
    i_rsp_id    = '0;
    for (int k = 0; k < NP; k++) i_req_data[k*DW +: DW] = pay(k, 8'hA0);
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  initial begin : stim
    int acc;
    rstn        = 1'b0;
    i_req_valid = '1;
    i_req_data  = '0;
    i_ready     = 1'b1;
    i_rsp_valid = 1'b0;
    i_rsp_id    = '0;
    #3;
    chk("rst_ready", o_req_ready, '0);
    chk("rst_valid", o_valid, 0);
    chk("rst_outst", o_outst, 0);
    chk("rst_err", o_err, 0);

    // all ports valid, immediate responses: 0..10,0
    reset_dut();
    i_req_valid = '1;
    i_ready     = 1'b1;
    #1;
    chk("t1_rdy0", o_req_ready, oh(0));
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n >= 2) begin
        i_rsp_valid = 1'b1;
        i_rsp_id    = 4'((n - 2) % NP);
      end
      #1;
      chk("t1_id", o_port_id, (n - 1) % NP);
      chk("t1_data", o_data, pay((n - 1) % NP, 8'hA0));
      chk("t1_rdy", o_req_ready, oh(n % NP));
      chk("t1_outst", o_outst, (n >= 2) ? 1 : 0);
      if (n >= 2) chk("t1_rsp", o_rsp_valid, oh((n - 2) % NP));
    end

    // ports 3 and 7 after last grant 5
    reset_dut();
    i_ready     = 1'b1;
    i_req_valid = oh(5);
    #1;
    chk("t2_rdy5", o_req_ready, oh(5));
    tick();
    i_req_valid = oh(3) | oh(7);
    #1;
    chk("t2_id5", o_port_id, 5);
    chk("t2_rdy7a", o_req_ready, oh(7));
    tick();
    chk("t2_id7a", o_port_id, 7);
    chk("t2_rdy3", o_req_ready, oh(3));
    tick();
    chk("t2_id3", o_port_id, 3);
    chk("t2_rdy7b", o_req_ready, oh(7));
    tick();
    chk("t2_id7b", o_port_id, 7);
    chk("t2_outst3", o_outst, 3);
    chk("t2_rdy_blk", o_req_ready, '0);
    tick();
    chk("t2_outst4", o_outst, 4);
    chk("t2_drained", o_valid, 0);

    // outstanding limit with port 0 always valid
    reset_dut();
    i_req_valid = oh(0);
    i_ready     = 1'b1;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (o_req_ready[0]) acc++;
      tick();
    end
    chk("t3_accepts", acc, 4);
    chk("t3_outst4", o_outst, 4);
    chk("t3_rdy_blk", o_req_ready, '0);
    chk("t3_drained", o_valid, 0);
    i_rsp_valid = 1'b1;
    i_rsp_id    = 4'd0;
    #1;
    chk("t3_rsp0", o_rsp_valid, oh(0));
    chk("t3_rdy_rsp", o_req_ready, '0);
    tick();
    i_rsp_valid = 1'b0;
    #1;
    chk("t3_outst3", o_outst, 3);
    chk("t3_rdy_again", o_req_ready, oh(0));
    tick();
    chk("t3_slot", o_valid, 1);
    chk("t3_rdy_blk2", o_req_ready, '0);
    tick();
    chk("t3_outst4b", o_outst, 4);

    // slot hold under backpressure
    reset_dut();
    i_req_valid = oh(2);
    i_ready     = 1'b0;
    #1;
    chk("t4_rdy2", o_req_ready, oh(2));
    tick();
    i_req_data[2*DW +: DW] = pay(2, 8'h5C);
    i_req_valid = oh(2) | oh(3) | oh(4);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t4_hold_id", o_port_id, 2);
      chk("t4_hold_data", o_data, pay(2, 8'hA0));
      chk("t4_hold_rdy", o_req_ready, '0);
      tick();
    end
    i_req_valid = oh(2) | oh(4);
    i_ready     = 1'b1;
    #1;
    chk("t4_rdy4", o_req_ready, oh(4));
    tick();
    chk("t4_id4", o_port_id, 4);
    chk("t4_data4", o_data, pay(4, 8'hA0));
    chk("t4_outst1", o_outst, 1);

    // response with nothing outstanding
    reset_dut();
    i_rsp_valid = 1'b1;
    i_rsp_id    = 4'd3;
    #1;
    chk("t5_rsp_none", o_rsp_valid, '0);
    tick();
    i_rsp_valid = 1'b0;
    #1;
    chk("t5_err", o_err, 1);
    chk("t5_outst0", o_outst, 0);
    tick();
    tick();
    chk("t5_err_sticky", o_err, 1);

    // out-of-range response id with one outstanding
    reset_dut();
    i_req_valid = oh(1);
    i_ready     = 1'b1;
    tick();
    i_req_valid = '0;
    tick();
    chk("t5_outst1", o_outst, 1);
    chk("t5_err_clr", o_err, 0);
    i_rsp_valid = 1'b1;
    i_rsp_id    = 4'd12;
    #1;
    chk("t5_rsp12", o_rsp_valid, '0);
    tick();
    i_rsp_id = 4'd1;
    #1;
    chk("t5_err12", o_err, 1);
    chk("t5_outst_keep", o_outst, 1);
    chk("t5_rsp1", o_rsp_valid, oh(1));
    tick();
    i_rsp_valid = 1'b0;
    #1;
    chk("t5_outst_dec", o_outst, 0);
    chk("t5_err_keep", o_err, 1);

    // reset in the middle of traffic
    reset_dut();
    i_rsp_valid = 1'b1;
    i_rsp_id    = 4'd0;
    i_req_valid = oh(0);
    i_ready     = 1'b1;
    tick();
    i_rsp_valid = 1'b0;
    repeat (3) tick();
    chk("t6_pre_valid", o_valid, 1);
    chk("t6_pre_outst", o_outst, 3);
    chk("t6_pre_err", o_err, 1);
    rstn        = 1'b0;
    i_req_valid = oh(0) | oh(3);
    i_rsp_valid = 1'b1;
    #1;
    chk("t6_valid", o_valid, 0);
    chk("t6_data", o_data, 0);
    chk("t6_id", o_port_id, 0);
    chk("t6_outst", o_outst, 0);
    chk("t6_err", o_err, 0);
    chk("t6_rdy", o_req_ready, '0);
    chk("t6_rsp", o_rsp_valid, '0);
    tick();
    i_rsp_valid = 1'b0;
    rstn        = 1'b1;
    #1;
    chk("t6_rdy0", o_req_ready, oh(0));
    tick();
    chk("t6_first_id", o_port_id, 0);
    chk("t6_first_valid", o_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mmu_rr_arb_sched.md
MMU_RR_ARB_SCHED -- requirements
Module: mmu_rr_arb_sched

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 11: number of requesters.
REQ-002 SHALL have parameter DATA_WIDTH, default 88: request payload width.
REQ-003 SHALL have parameter MAX_OUTST, default 4: maximum accepted-but-unanswered transactions (1..15).
REQ-004 SHALL have port clk  input  1: rising-edge clock.
REQ-005 SHALL have port rstn  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port i_req_valid  input  NUM_PORTS: per-port request valid.
REQ-007 SHALL have port i_req_data  input  NUM_PORTS*DATA_WIDTH: payloads; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-008 SHALL have port o_req_ready  output  NUM_PORTS: per-port accept, at most one bit high per cycle.
REQ-009 SHALL have port o_valid  output  1: merged request valid.
REQ-010 SHALL have port o_data  output  DATA_WIDTH: merged payload.
REQ-011 SHALL have port o_port_id  output  4: source port index of o_data.
REQ-012 SHALL have port i_ready  input  1: downstream accepts o_data.
REQ-013 SHALL have port i_rsp_valid  input  1: downstream completion pulse.
REQ-014 SHALL have port i_rsp_id  input  4: port index of the completion.
REQ-015 SHALL have port o_rsp_valid  output  NUM_PORTS: one-hot completion routed to requester.
REQ-016 SHALL have port o_outst  output  4: current outstanding count.
REQ-017 SHALL have port o_err  output  1: sticky protocol-error flag.

Function
REQ-018 SHALL hold a single registered output slot (o_valid, o_data, o_port_id); o_data and o_port_id stable while o_valid=1 and i_ready=0.
REQ-019 SHALL define slot_free = ~o_valid | i_ready; define can_issue = slot_free & (o_outst + accept_now_pending) < MAX_OUTST, where accept_now_pending = o_valid & i_ready.
REQ-020 SHALL, when can_issue and any i_req_valid, grant exactly one port: the first valid port scanning from (last_grant+1) mod NUM_PORTS upward with wrap.
REQ-021 SHALL assert o_req_ready[g] combinationally in that cycle only for granted port g; handshake completes on i_req_valid[g] & o_req_ready[g].
REQ-022 SHALL load the slot with port g payload and id at the next edge; latency request-to-o_valid is exactly 1 cycle.
REQ-023 SHALL update last_grant to g only on a completed handshake; no request leaves pointer unchanged.
REQ-024 SHALL clear o_valid at the edge where o_valid & i_ready and no new grant occurs; back-to-back grants SHALL sustain one transfer per cycle.
REQ-025 SHALL increment o_outst on o_valid & i_ready, decrement on valid i_rsp_valid, leave it unchanged when both occur in one cycle.
REQ-026 SHALL block all grants (o_req_ready=0) while issued-or-in-slot count reaches MAX_OUTST; the slot content SHALL still drain.
REQ-027 SHALL drive o_rsp_valid[i_rsp_id]=1 combinationally with i_rsp_valid when i_rsp_id < NUM_PORTS and o_outst > 0.
REQ-028 SHALL, on i_rsp_valid with o_outst=0 or i_rsp_id >= NUM_PORTS, not alter o_outst, drive o_rsp_valid=0, and set o_err=1 until reset.
REQ-029 SHALL ignore payload of non-granted ports; a port dropping i_req_valid before grant SHALL not be granted.
REQ-030 SHALL guarantee no port waits more than NUM_PORTS grants while continuously valid.

Reset
REQ-031 SHALL, on rstn=0, asynchronously set o_valid=0, o_data=0, o_port_id=0, o_outst=0, o_err=0, last_grant=NUM_PORTS-1 (first scan starts at port 0).
REQ-032 SHALL drive o_req_ready=0 and o_rsp_valid=0 while rstn=0; reset mid-transfer SHALL discard slot content and outstanding count.
REQ-033 SHALL resume granting on the first rising edge after rstn deasserts.

Verification
REQ-034 SHALL test: all 11 ports valid, i_ready=1, responses immediate -> o_port_id sequence 0,1,2,...,10,0 one per cycle.
REQ-035 SHALL test: ports 3 and 7 valid, last_grant=5 -> grant 7, then 3, then 7.
REQ-036 SHALL test: MAX_OUTST=4, no responses, port 0 valid, i_ready=1 -> exactly 4 accepts, o_outst=4, o_req_ready=0 thereafter; one i_rsp_valid id=0 -> o_rsp_valid[0]=1, one more accept.
REQ-037 SHALL test: i_ready=0 with o_valid=1 for 5 cycles -> o_data/o_port_id unchanged, o_req_ready all 0; i_ready=1 -> transfer and new grant same cycle.
REQ-038 SHALL test: i_rsp_valid with o_outst=0 -> o_err=1 sticky, o_outst stays 0; i_rsp_id=12 -> o_err=1, no o_rsp_valid.
REQ-039 SHALL test: rstn pulsed low with o_valid=1, o_outst=3 -> all outputs 0 immediately, next grant port 0.
